// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus for the fetch unit.
// master: fetch unit (req/addr out); slave: memory (gnt/rvalid/rdata out).
interface if_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch front end: sequential PC, one outstanding imem request, skid buffer.
// Ports: clk/rst, stall_i, flush_i/flush_pc_i, imem bus, pc_o/inst_o/inst_valid_o.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  if_fetch_unit_if.master imem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic gnt_ok;
  logic resp;
  logic unused_flush_lsb;

  assign gnt_ok = (state_q == S_REQ) && imem.imem_gnt_i;
  assign resp   = (state_q == S_WAIT) && imem.imem_rvalid_i;
  assign unused_flush_lsb = ^flush_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      pc_q        <= 32'h0;
      inst_q      <= NOP_INST;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  // A response that finds the output full and stalled parks in the
  // buffer; HOLD then blocks new requests until it drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (imem.imem_gnt_i)
          state_d = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush_i)
          state_d = imem.imem_rvalid_i ? S_REQ : S_DRAIN;
        else if (imem.imem_rvalid_i)
          state_d = (stall_i && out_valid_q) ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        if (flush_i || !stall_i)
          state_d = S_REQ;
      end
      S_DRAIN: begin
        // Once the stale response is gone nothing is outstanding,
        // even if another flush lands in the same cycle.
        if (imem.imem_rvalid_i)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;

    if (gnt_ok) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

    if (!stall_i) begin
      if (buf_valid_q) begin
        out_valid_d = 1'b1;
        pc_d        = buf_pc_q;
        inst_d      = buf_inst_q;
        buf_valid_d = 1'b0;
      end else if (resp) begin
        out_valid_d = 1'b1;
        pc_d        = req_pc_q;
        inst_d      = imem.imem_rdata_i;
      end else begin
        out_valid_d = 1'b0;
        inst_d      = NOP_INST;
      end
    end else if (resp) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        pc_d        = req_pc_q;
        inst_d      = imem.imem_rdata_i;
      end else begin
        buf_valid_d = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_inst_d  = imem.imem_rdata_i;
      end
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
      inst_d      = NOP_INST;
      buf_valid_d = 1'b0;
      fetch_pc_d  = {flush_pc_i[31:2], 2'b00};
    end
  end

  always_comb begin
    imem.imem_req_o  = (state_q == S_REQ) && !rst;
    imem.imem_addr_o = fetch_pc_q;
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = out_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scenario bench for if_fetch_unit with an in-order scoreboard.
// Tasks drive the imem bus directly and check timing inline.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  if_fetch_unit_if mif();

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .imem         (mif.master),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && !stall && inst_valid_o) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got pc=%h inst=%h, none expected",
                 pc_o, inst_o);
      end else begin
        e = exp_q.pop_front();
        if ({pc_o, inst_o} !== e) begin
          errors++;
          $display("FAIL sb_order: got %h/%h want %h/%h",
                   pc_o, inst_o, e[63:32], e[31:0]);
        end
      end
    end
    if (!rst && !inst_valid_o) begin
      checks++;
      if (inst_o !== NOP) begin
        errors++;
        $display("FAIL nop_fill: got %h want %h", inst_o, NOP);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({mif.imem_req_o, inst_valid_o, pc_o, inst_o, mif.imem_addr_o}
        !== {1'b0, 1'b0, 32'h0, NOP, 32'h0}) begin
      errors++;
      $display("FAIL reset_vals: req=%b v=%b pc=%h inst=%h addr=%h",
               mif.imem_req_o, inst_valid_o, pc_o, inst_o,
               mif.imem_addr_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mif.imem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_req: got %b want 1", mif.imem_req_o);
    end
  endtask

  task automatic test_zero_wait;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, d;
      a = 32'(i * 4);
      d = $urandom;
      checks++;
      if ({mif.imem_req_o, mif.imem_addr_o} !== {1'b1, a}) begin
        errors++;
        $display("FAIL zw_req: got %b/%h want 1/%h",
                 mif.imem_req_o, mif.imem_addr_o, a);
      end
      mif.imem_gnt_i = 1'b1;
      tick();
      mif.imem_gnt_i = 1'b0;
      checks++;
      if ({mif.imem_req_o, inst_valid_o} !== 2'b00) begin
        errors++;
        $display("FAIL zw_wait: got req=%b v=%b want 0/0",
                 mif.imem_req_o, inst_valid_o);
      end
      mif.imem_rvalid_i = 1'b1;
      mif.imem_rdata_i = d;
      exp_q.push_back({a, d});
      tick();
      mif.imem_rvalid_i = 1'b0;
      checks++;
      if ({inst_valid_o, pc_o, inst_o} !== {1'b1, a, d}) begin
        errors++;
        $display("FAIL zw_out: got %b/%h/%h want 1/%h/%h",
                 inst_valid_o, pc_o, inst_o, a, d);
      end
    end
  endtask

  task automatic test_wait_delay;
    logic [31:0] d;
    d = $urandom;
    do_reset();
    repeat (3) begin
      checks++;
      if ({mif.imem_req_o, mif.imem_addr_o} !== {1'b1, 32'h0}) begin
        errors++;
        $display("FAIL wd_addr: got %b/%h want 1/0",
                 mif.imem_req_o, mif.imem_addr_o);
      end
      tick();
    end
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    repeat (3) begin
      checks++;
      if ({mif.imem_req_o, inst_valid_o} !== 2'b00) begin
        errors++;
        $display("FAIL wd_idle: got req=%b v=%b want 0/0",
                 mif.imem_req_o, inst_valid_o);
      end
      tick();
    end
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d;
    exp_q.push_back({32'h0, d});
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, pc_o, inst_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b1, 32'h0, d, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL wd_out: got %b/%h/%h req=%b addr=%h",
               inst_valid_o, pc_o, inst_o, mif.imem_req_o,
               mif.imem_addr_o);
    end
    tick();
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wd_once: got v=%b want 0", inst_valid_o);
    end
  endtask

  task automatic test_stall_skid;
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    do_reset();
    stall = 1'b1;
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d0;
    exp_q.push_back({32'h0, d0});
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, pc_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b1, 32'h0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL sk_first: got v=%b pc=%h req=%b addr=%h",
               inst_valid_o, pc_o, mif.imem_req_o, mif.imem_addr_o);
    end
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d1;
    exp_q.push_back({32'h4, d1});
    tick();
    mif.imem_rvalid_i = 1'b0;
    repeat (2) begin
      checks++;
      if ({mif.imem_req_o, inst_valid_o, pc_o, inst_o}
          !== {1'b0, 1'b1, 32'h0, d0}) begin
        errors++;
        $display("FAIL sk_hold: got req=%b v=%b pc=%h inst=%h",
                 mif.imem_req_o, inst_valid_o, pc_o, inst_o);
      end
      tick();
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({inst_valid_o, pc_o, inst_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b1, 32'h4, d1, 1'b1, 32'h8}) begin
      errors++;
      $display("FAIL sk_second: got %b/%h/%h req=%b addr=%h",
               inst_valid_o, pc_o, inst_o, mif.imem_req_o,
               mif.imem_addr_o);
    end
    tick();
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sk_after: got v=%b want 0", inst_valid_o);
    end
  endtask

  task automatic test_flush_wait;
    logic [31:0] d;
    d = $urandom;
    do_reset();
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h0000_1002;
    tick();
    flush = 1'b0;
    repeat (2) begin
      checks++;
      if ({mif.imem_req_o, inst_valid_o} !== 2'b00) begin
        errors++;
        $display("FAIL fl_drain: got req=%b v=%b want 0/0",
                 mif.imem_req_o, inst_valid_o);
      end
      tick();
    end
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b0, 1'b1, 32'h0000_1000}) begin
      errors++;
      $display("FAIL fl_redir: got v=%b req=%b addr=%h",
               inst_valid_o, mif.imem_req_o, mif.imem_addr_o);
    end
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d;
    exp_q.push_back({32'h0000_1000, d});
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0000_1000, d}) begin
      errors++;
      $display("FAIL fl_out: got %b/%h/%h want 1/00001000/%h",
               inst_valid_o, pc_o, inst_o, d);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    d = $urandom;
    do_reset();
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    checks++;
    if ({mif.imem_req_o, mif.imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wr_addr: got %b/%h want 1/fffffffc",
               mif.imem_req_o, mif.imem_addr_o);
    end
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d;
    exp_q.push_back({32'hFFFF_FFFC, d});
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, pc_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wr_next: got v=%b pc=%h req=%b addr=%h",
               inst_valid_o, pc_o, mif.imem_req_o, mif.imem_addr_o);
    end
  endtask

  task automatic test_rst_flush_stall;
    logic [31:0] d;
    d = $urandom;
    do_reset();
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({mif.imem_req_o, inst_valid_o, pc_o, inst_o, mif.imem_addr_o}
        !== {1'b0, 1'b0, 32'h0, NOP, 32'h0}) begin
      errors++;
      $display("FAIL rf_rst: got req=%b v=%b pc=%h inst=%h addr=%h",
               mif.imem_req_o, inst_valid_o, pc_o, inst_o,
               mif.imem_addr_o);
    end
    rst = 1'b0;
    #1;
    stall = 1'b1;
    mif.imem_gnt_i = 1'b1;
    tick();
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b1;
    mif.imem_rdata_i = d;
    tick();
    mif.imem_rvalid_i = 1'b0;
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0, d}) begin
      errors++;
      $display("FAIL rf_held: got %b/%h/%h want 1/0/%h",
               inst_valid_o, pc_o, inst_o, d);
    end
    flush = 1'b1;
    flush_pc = 32'h0000_2000;
    tick();
    flush = 1'b0;
    checks++;
    if ({inst_valid_o, inst_o, mif.imem_req_o, mif.imem_addr_o}
        !== {1'b0, NOP, 1'b1, 32'h0000_2000}) begin
      errors++;
      $display("FAIL rf_flush: got v=%b inst=%h req=%b addr=%h",
               inst_valid_o, inst_o, mif.imem_req_o, mif.imem_addr_o);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rf_after: got v=%b want 0", inst_valid_o);
    end
  endtask

  initial begin
    mif.imem_gnt_i = 1'b0;
    mif.imem_rvalid_i = 1'b0;
    mif.imem_rdata_i = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_delay();
    test_stall_skid();
    test_flush_wait();
    test_wrap();
    test_rst_flush_stall();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_left: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
